// File: rtl/branch_redirect_unit_pkg.sv
// rtl/branch_redirect_unit_pkg.sv - processor-wide opcodes, instruction field positions and redirect FSM states
package branch_redirect_unit_pkg;

    localparam logic [4:0] OP_J   = 5'b00001;
    localparam logic [4:0] OP_BNE = 5'b00010;
    localparam logic [4:0] OP_JAL = 5'b00011;
    localparam logic [4:0] OP_JR  = 5'b00100;
    localparam logic [4:0] OP_BLT = 5'b00110;
    localparam logic [4:0] OP_BEX = 5'b10110;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 27;
    localparam int TGT_HI = 26;
    localparam int TGT_LO = 0;
    localparam int IMM_HI = 16;
    localparam int IMM_LO = 0;

    typedef enum logic {
        IDLE   = 1'b0,
        SHADOW = 1'b1
    } redirect_state_t;

    function automatic logic [31:0] sextImm(input logic [16:0] imm);
        return {{15{imm[16]}}, imm};
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// rtl/branch_cond_eval.sv - combinational branch decode, condition and target evaluation
module branch_cond_eval
    import branch_redirect_unit_pkg::*;
(
    input  logic [4:0]  opcode,
    input  logic [26:0] jumpTarget,
    input  logic [16:0] imm,
    input  logic [31:0] pcX,
    input  logic [31:0] rdVal,
    input  logic [31:0] rsVal,
    input  logic [31:0] rstatusVal,
    output logic        isBranch,
    output logic        cond,
    output logic [31:0] target
);

    logic [31:0] relTarget;

    // Relative branches wrap silently modulo 2^32.
    assign relTarget = pcX + 32'd1 + sextImm(imm);

    always_comb begin
        isBranch = 1'b0;
        cond     = 1'b0;
        target   = 32'b0;
        case (opcode)
            OP_J, OP_JAL: begin
                isBranch = 1'b1;
                cond     = 1'b1;
                target   = {5'b0, jumpTarget};
            end
            OP_BEX: begin
                isBranch = 1'b1;
                cond     = (rstatusVal != 32'b0);
                target   = {5'b0, jumpTarget};
            end
            OP_JR: begin
                isBranch = 1'b1;
                cond     = 1'b1;
                target   = rdVal;
            end
            OP_BNE: begin
                isBranch = 1'b1;
                cond     = (rdVal != rsVal);
                target   = relTarget;
            end
            OP_BLT: begin
                isBranch = 1'b1;
                cond     = ($signed(rdVal) < $signed(rsVal));
                target   = relTarget;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/branch_redirect_unit.sv
// rtl/branch_redirect_unit.sv - execute-stage redirect, wrong-path squash FSM and branch statistics
module branch_redirect_unit
    import branch_redirect_unit_pkg::*;
#(
    parameter int SHADOW_DEPTH = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             valid_x,
    input  logic             stall,
    input  logic [31:0]      insn_x,
    input  logic [31:0]      pc_x,
    input  logic [31:0]      rd_val,
    input  logic [31:0]      rs_val,
    input  logic [31:0]      rstatus_val,
    output logic             branch_taken,
    output logic [31:0]      pc_target,
    output logic             flush_fd,
    output logic             flush_dx,
    output logic             in_shadow,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] taken_count
);

    localparam int SHW = (SHADOW_DEPTH < 1) ? 1 : $clog2(SHADOW_DEPTH + 1);
    localparam logic [SHW-1:0] SHADOW_LOAD = SHW'(SHADOW_DEPTH);

    redirect_state_t state;
    logic [SHW-1:0]  shadowCnt;
    logic            isBranch;
    logic            cond;
    logic [31:0]     target;
    logic            go;
    logic            takenNow;

    branch_cond_eval u_cond (
        .opcode     (insn_x[OPC_HI:OPC_LO]),
        .jumpTarget (insn_x[TGT_HI:TGT_LO]),
        .imm        (insn_x[IMM_HI:IMM_LO]),
        .pcX        (pc_x),
        .rdVal      (rd_val),
        .rsVal      (rs_val),
        .rstatusVal (rstatus_val),
        .isBranch   (isBranch),
        .cond       (cond),
        .target     (target)
    );

    // Reset gates every combinational output so nothing leaks while reset is low.
    assign go           = reset & valid_x & ~stall & (state == IDLE);
    assign takenNow     = go & isBranch & cond;
    assign branch_taken = takenNow;
    assign pc_target    = takenNow ? target : 32'b0;
    assign flush_fd     = takenNow;
    assign flush_dx     = takenNow;
    assign in_shadow    = reset & (state == SHADOW);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            shadowCnt   <= '0;
            br_count    <= '0;
            taken_count <= '0;
        end else begin
            if (go && isBranch) begin
                br_count <= br_count + CNT_W'(1);
            end
            if (takenNow) begin
                taken_count <= taken_count + CNT_W'(1);
            end
            case (state)
                IDLE: begin
                    if (takenNow && (SHADOW_DEPTH != 0)) begin
                        state     <= SHADOW;
                        shadowCnt <= SHADOW_LOAD;
                    end
                end
                SHADOW: begin
                    // A stalled pipeline holds the squashed slots in place.
                    if (!stall) begin
                        shadowCnt <= shadowCnt - SHW'(1);
                        if (shadowCnt == SHW'(1)) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/branch_redirect_unit.md
Name: branch_redirect_unit

Overview:
- Sits in the execute stage and drives the redirect side of the fetch PC-select interface: the branch-taken flag and the execute-stage target PC that fetch muxes against PC+1.
- Resolves j/bne/jal/jr/blt/bex from the execute-stage instruction and bypassed operands.
- Squashes wrong-path instructions in fetch/decode via a shadow FSM and keeps branch statistics counters.

Parameters:
- SHADOW_DEPTH, 2, number of younger pipeline slots squashed after a taken redirect (F/D and D/X latches).
- CNT_W, 32, width of the statistics counters.

Ports:
- clock  input  1  pipeline clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low; clears all state immediately when 0.
- valid_x  input  1  execute-stage slot holds a real, non-squashed instruction.
- stall  input  1  pipeline freeze (multdiv busy); the execute slot is held.
- insn_x  input  32  execute-stage instruction.
- pc_x  input  32  PC of the execute-stage instruction.
- rd_val  input  32  bypassed $rd value.
- rs_val  input  32  bypassed $rs value.
- rstatus_val  input  32  bypassed $r30 value.
- branch_taken  output  1  redirect strobe to fetch.
- pc_target  output  32  redirect PC to fetch; valid when branch_taken=1.
- flush_fd  output  1  convert the F/D latch contents to a nop on the next edge.
- flush_dx  output  1  convert the D/X latch contents to a nop on the next edge.
- in_shadow  output  1  FSM is in SHADOW state.
- br_count  output  CNT_W  number of branch/jump instructions resolved.
- taken_count  output  CNT_W  number of redirects issued.

Behaviour:
- Decode, opcode = insn_x[31:27]:
  - j=00001, jal=00011: always taken; target={5'b0,insn_x[26:0]}.
  - bex=10110: taken iff rstatus_val!=0; target={5'b0,insn_x[26:0]}.
  - jr=00100: always taken; target=rd_val.
  - bne=00010: taken iff rd_val!=rs_val.
  - blt=00110: taken iff $signed(rd_val)<$signed(rs_val).
  - bne/blt target = pc_x + 1 + sign-extended insn_x[16:0], mod 2^32; wrap-around is silent, no overflow flag.
  - All other opcodes are non-branches.
- Qualifier: go = valid_x & ~stall & (state==IDLE).
- Outputs, all combinational, zero latency:
  - branch_taken = go & is_branch & cond.
  - pc_target = target whenever branch_taken=1; otherwise 32'b0.
  - flush_fd = flush_dx = branch_taken.
  - in_shadow = (state==SHADOW).
- FSM states IDLE and SHADOW:
  - IDLE -> SHADOW on a clock edge where branch_taken=1; loads shadow_cnt=SHADOW_DEPTH.
  - In SHADOW, each edge with stall=0 decrements shadow_cnt.
  - SHADOW -> IDLE on the edge where shadow_cnt goes 1 -> 0.
  - While stall=1, shadow_cnt holds.
  - No redirect is issued while in SHADOW, regardless of valid_x, so squashed wrong-path branches cannot redirect.
- Stall: a branch held across stalled cycles produces branch_taken exactly once, on its first cycle with stall=0.
- Counters:
  - br_count += 1 on each edge where go & is_branch.
  - taken_count += 1 on each edge where branch_taken.
  - Both wrap modulo 2^CNT_W.
- Reset (reset=0, asynchronous): state=IDLE, shadow_cnt=0, br_count=0, taken_count=0.
  - Outputs under reset: branch_taken=0, pc_target=0, flush_fd=0, flush_dx=0, in_shadow=0.
  - All combinational outputs are gated by reset.
  - Reset asserted mid-SHADOW returns to IDLE immediately.
- SHADOW_DEPTH=0 is legal: the FSM never leaves IDLE.

Decomposition:
- Shared package (processor-wide constants):
  - opcode localparams OP_J, OP_BNE, OP_JAL, OP_JR, OP_BLT, OP_BEX.
  - field slice positions (opcode [31:27], target [26:0], immediate [16:0]).
- One sub-module, branch_cond_eval: purely combinational. Takes opcode and operands; outputs is_branch, cond and target.
- The top level holds the FSM, the shadow counter and the statistics counters.

Test Plan:
- bne, pc_x=0x10, imm=17'h1FFFE (-2), rd_val=5, rs_val=3, valid_x=1 -> branch_taken=1, pc_target=0x0F, flush_fd=flush_dx=1. Next cycle in_shadow=1; IDLE after 2 unstalled cycles; taken_count=1.
- blt, rd_val=0xFFFFFFFF (-1), rs_val=1 -> taken. Then rd_val=1, rs_val=0xFFFFFFFF -> not taken; br_count increments both times, taken_count only once.
- jr with rd_val=0x00ABCDEF, stall=1 for 3 cycles then 0 -> branch_taken=0 during stall, exactly one pulse with pc_target=0x00ABCDEF on the release cycle.
- j to 0x100 immediately followed by bne (taken operands) in the next two valid slots -> only the j redirects; br_count=1, taken_count=1.
- bex with rstatus_val=0 -> no redirect. With rstatus_val=7, target 27'h1234 -> pc_target=0x00001234.
- Assert reset=0 asynchronously mid-SHADOW, between clock edges -> in_shadow and counters clear immediately. After release, a taken j redirects on the first valid cycle.
